// File: rtl/nand_gates_pkg.sv
// -----------------------------------------------------------------------------
// nand_gates_pkg
//
// Shared definitions for the nand_gates logic-gate unit.
//
// Contents:
//   GATE_*     index constants naming each two-input gate function. The
//              current unit evaluates every function at once. A select-based
//              variant can reuse the same numbering.
//   NUM_GATES  number of functions the unit provides.
//   gate_fn()  single-bit evaluation of one gate function, selected by index.
//
// No ports (package).
// -----------------------------------------------------------------------------
package nand_gates_pkg;

    localparam int unsigned GATE_AND   = 0;
    localparam int unsigned GATE_OR    = 1;
    localparam int unsigned GATE_NAND  = 2;
    localparam int unsigned GATE_NOR   = 3;
    localparam int unsigned GATE_XOR   = 4;
    localparam int unsigned GATE_XNOR  = 5;
    localparam int unsigned GATE_NOT_A = 6;

    localparam int unsigned NUM_GATES  = 7;

    // Evaluate one gate function on a single bit pair. Plain Verilog
    // operators are used so that X/Z inputs propagate naturally instead of
    // being forced to a known value.
    function automatic logic gate_fn(input int unsigned sel,
                                     input logic        a,
                                     input logic        b);
        logic r;
        case (sel)
            GATE_AND:   r = a & b;
            GATE_OR:    r = a | b;
            GATE_NAND:  r = ~(a & b);
            GATE_NOR:   r = ~(a | b);
            GATE_XOR:   r = a ^ b;
            GATE_XNOR:  r = ~(a ^ b);
            GATE_NOT_A: r = ~a;
            default:    r = 1'b0;
        endcase
        return r;
    endfunction

endpackage : nand_gates_pkg

// File: rtl/nand_gates_gate_bitslice.sv
// -----------------------------------------------------------------------------
// gate_bitslice
//
// One bit of the nand_gates unit. It evaluates all seven basic gate functions
// of a single operand bit pair. The slice is purely combinational and has no
// clock or reset.
//
// Ports:
//   a        input   operand A bit
//   b        input   operand B bit
//   and_o    output  a & b
//   or_o     output  a | b
//   nand_o   output  ~(a & b)
//   nor_o    output  ~(a | b)
//   xor_o    output  a ^ b
//   xnor_o   output  ~(a ^ b)
//   not_a_o  output  ~a
// -----------------------------------------------------------------------------
module gate_bitslice
    import nand_gates_pkg::*;
(
    input  logic a,
    input  logic b,
    output logic and_o,
    output logic or_o,
    output logic nand_o,
    output logic nor_o,
    output logic xor_o,
    output logic xnor_o,
    output logic not_a_o
);

    assign and_o   = gate_fn(GATE_AND,   a, b);
    assign or_o    = gate_fn(GATE_OR,    a, b);
    assign nand_o  = gate_fn(GATE_NAND,  a, b);
    assign nor_o   = gate_fn(GATE_NOR,   a, b);
    assign xor_o   = gate_fn(GATE_XOR,   a, b);
    assign xnor_o  = gate_fn(GATE_XNOR,  a, b);
    assign not_a_o = gate_fn(GATE_NOT_A, a, b);

endmodule : gate_bitslice

// File: rtl/nand_gates.sv
// -----------------------------------------------------------------------------
// nand_gates
//
// Two-input bitwise logic-gate unit with NAND as the primary function. The
// output y is the combinational NAND of a and b. A registered bank captures
// all basic gate results for synchronous consumers.
//
// Parameters:
//   WIDTH    operand and result width in bits (>= 1)
//
// Ports (the declaration order is fixed, so a positional a, b, y hookup works):
//   a        input   [WIDTH]  operand A
//   b        input   [WIDTH]  operand B
//   y        output  [WIDTH]  combinational ~(a & b), independent of clk and rst
//   clk      input            rising-edge clock for the register bank
//   rst      input            synchronous active-high reset of the bank
//   en       input            bank load enable (level sampled)
//   and_q    output  [WIDTH]  registered a & b
//   or_q     output  [WIDTH]  registered a | b
//   nand_q   output  [WIDTH]  registered ~(a & b)
//   nor_q    output  [WIDTH]  registered ~(a | b)
//   xor_q    output  [WIDTH]  registered a ^ b
//   xnor_q   output  [WIDTH]  registered ~(a ^ b)
//   not_a_q  output  [WIDTH]  registered ~a
//   valid_q  output           the bank holds a loaded result
//
// Reset clears every bank output to 0. This includes the inverting functions,
// so consumers must qualify the bank with valid_q.
// -----------------------------------------------------------------------------
module nand_gates
    import nand_gates_pkg::*;
#(
    parameter int unsigned WIDTH = 1
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] y,
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    output logic [WIDTH-1:0] and_q,
    output logic [WIDTH-1:0] or_q,
    output logic [WIDTH-1:0] nand_q,
    output logic [WIDTH-1:0] nor_q,
    output logic [WIDTH-1:0] xor_q,
    output logic [WIDTH-1:0] xnor_q,
    output logic [WIDTH-1:0] not_a_q,
    output logic             valid_q
);

    // Combinational gate results, assembled from the bit slices.
    logic [WIDTH-1:0] and_c;
    logic [WIDTH-1:0] or_c;
    logic [WIDTH-1:0] nand_c;
    logic [WIDTH-1:0] nor_c;
    logic [WIDTH-1:0] xor_c;
    logic [WIDTH-1:0] xnor_c;
    logic [WIDTH-1:0] not_a_c;

    // Next-state values for the register bank.
    logic [WIDTH-1:0] and_d;
    logic [WIDTH-1:0] or_d;
    logic [WIDTH-1:0] nand_d;
    logic [WIDTH-1:0] nor_d;
    logic [WIDTH-1:0] xor_d;
    logic [WIDTH-1:0] xnor_d;
    logic [WIDTH-1:0] not_a_d;
    logic             valid_d;

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_slice
            gate_bitslice u_slice (
                .a       (a[gi]),
                .b       (b[gi]),
                .and_o   (and_c[gi]),
                .or_o    (or_c[gi]),
                .nand_o  (nand_c[gi]),
                .nor_o   (nor_c[gi]),
                .xor_o   (xor_c[gi]),
                .xnor_o  (xnor_c[gi]),
                .not_a_o (not_a_c[gi])
            );
        end
    endgenerate

    // The primary output comes straight from the slices. It does not depend on
    // the clock or reset, so it works even when clk, rst and en are left
    // unconnected.
    assign y = nand_c;

    // Load when enabled, otherwise hold. Reset is applied in the flop block so
    // that it takes priority over en.
    always_comb begin
        and_d   = and_q;
        or_d    = or_q;
        nand_d  = nand_q;
        nor_d   = nor_q;
        xor_d   = xor_q;
        xnor_d  = xnor_q;
        not_a_d = not_a_q;
        valid_d = valid_q;
        if (en) begin
            and_d   = and_c;
            or_d    = or_c;
            nand_d  = nand_c;
            nor_d   = nor_c;
            xor_d   = xor_c;
            xnor_d  = xnor_c;
            not_a_d = not_a_c;
            valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            and_q   <= '0;
            or_q    <= '0;
            nand_q  <= '0;
            nor_q   <= '0;
            xor_q   <= '0;
            xnor_q  <= '0;
            not_a_q <= '0;
            valid_q <= 1'b0;
        end else begin
            and_q   <= and_d;
            or_q    <= or_d;
            nand_q  <= nand_d;
            nor_q   <= nor_d;
            xor_q   <= xor_d;
            xnor_q  <= xnor_d;
            not_a_q <= not_a_d;
            valid_q <= valid_d;
        end
    end

endmodule : nand_gates

// File: tb/tb_nand_gates.sv
module tb_nand_gates;

    localparam int W = 4;

    typedef struct packed {
        logic [W-1:0] and_v;
        logic [W-1:0] or_v;
        logic [W-1:0] nand_v;
        logic [W-1:0] nor_v;
        logic [W-1:0] xor_v;
        logic [W-1:0] xnor_v;
        logic [W-1:0] nota_v;
        logic         valid;
    } bank_t;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         en  = 1'b0;
    logic [W-1:0] a   = '0;
    logic [W-1:0] b   = '0;
    logic [W-1:0] y;
    bank_t        got;

    // WIDTH=1 instance with its clock held idle, used for the combinational truth table only.
    logic a1 = 1'b0;
    logic b1 = 1'b0;
    logic y1;
    logic clk1 = 1'b0;
    logic rst1 = 1'b0;
    logic en1  = 1'b0;
    logic q1_and, q1_or, q1_nand, q1_nor, q1_xor, q1_xnor, q1_nota, q1_valid;

    int checks = 0;
    int fails  = 0;

    bank_t exp_q[$];
    bank_t model;

    always #5 clk = ~clk;

    nand_gates #(.WIDTH(W)) dut (
        .a(a), .b(b), .y(y), .clk(clk), .rst(rst), .en(en),
        .and_q(got.and_v), .or_q(got.or_v), .nand_q(got.nand_v),
        .nor_q(got.nor_v), .xor_q(got.xor_v), .xnor_q(got.xnor_v),
        .not_a_q(got.nota_v), .valid_q(got.valid)
    );

    nand_gates #(.WIDTH(1)) dut1 (
        .a(a1), .b(b1), .y(y1), .clk(clk1), .rst(rst1), .en(en1),
        .and_q(q1_and), .or_q(q1_or), .nand_q(q1_nand), .nor_q(q1_nor),
        .xor_q(q1_xor), .xnor_q(q1_xnor), .not_a_q(q1_nota), .valid_q(q1_valid)
    );

    // Truth tables indexed by {a,b}. Bit k of each table is the result for input pair k.
    function automatic logic [W-1:0] by_table(input logic [3:0] tbl,
                                              input logic [W-1:0] x,
                                              input logic [W-1:0] z);
        logic [W-1:0] r;
        for (int i = 0; i < W; i++) r[i] = tbl[{x[i], z[i]}];
        return r;
    endfunction

    function automatic bank_t eval(input logic [W-1:0] x, input logic [W-1:0] z);
        bank_t r;
        r.and_v  = by_table(4'b1000, x, z);
        r.or_v   = by_table(4'b1110, x, z);
        r.nand_v = by_table(4'b0111, x, z);
        r.nor_v  = by_table(4'b0001, x, z);
        r.xor_v  = by_table(4'b0110, x, z);
        r.xnor_v = by_table(4'b1001, x, z);
        r.nota_v = by_table(4'b0011, x, z);
        r.valid  = 1'b1;
        return r;
    endfunction

    // Drive one cycle of stimulus and record what the bank must hold after the next edge.
    task automatic drive(input logic r, input logic e, input logic [W-1:0] aa, input logic [W-1:0] bb);
        bank_t ev;
        @(negedge clk);
        rst = r; en = e; a = aa; b = bb;
        if (r)      model = '0;
        else if (e) model = eval(aa, bb);
        exp_q.push_back(model);
        #1;
        ev = eval(aa, bb);
        checks++;
        if (y !== ev.nand_v) begin
            fails++;
            $display("FAIL y_comb a=%b b=%b got=%b want=%b", aa, bb, y, ev.nand_v);
        end else
            $display("y a=%b b=%b y=%b", aa, bb, y);
    endtask

    // Monitor: compare the bank just after every rising edge that has a pending expectation.
    initial begin
        bank_t want;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() != 0) begin
                want = exp_q.pop_front();
                checks++;
                if (got !== want) begin
                    fails++;
                    $display("FAIL bank got=%h want=%h (and/or/nand/nor/xor/xnor/nota/valid)", got, want);
                end else
                    $display("bank ok %h rst=%b en=%b", got, rst, en);
            end
        end
    end

    initial begin
        logic [3:0] tab1;
        logic [1:0] idx;
        tab1  = 4'b0111;
        model = '0;
        // Step a/b through 00,01,10,11 on the WIDTH=1 instance.
        for (int i = 0; i < 4; i++) begin
            idx = i[1:0];
            a1 = idx[1]; b1 = idx[0];
            #1;
            checks++;
            if (y1 !== tab1[i]) begin
                fails++;
                $display("FAIL y1_truth ab=%b got=%b want=%b", idx, y1, tab1[i]);
            end else
                $display("y1 ab=%b y=%b", idx, y1);
            #9;
        end

        drive(1, 0, 4'h3, 4'h5);       // reset
        drive(0, 0, 4'h6, 4'h9);       // hold reset state, y still tracks inputs
        drive(0, 1, 4'hF, 4'h0);       // a=1 b=0 on every bit
        drive(0, 1, 4'hF, 4'hF);       // load a=1 b=1
        drive(0, 0, 4'h0, 4'h0);       // hold across three edges
        drive(0, 0, 4'h0, 4'h0);
        drive(0, 0, 4'h0, 4'h0);
        drive(0, 1, 4'hC, 4'hA);       // y=0111 xor=0110 nor=0001
        drive(1, 1, 4'h5, 4'h3);       // reset wins over en
        drive(0, 1, 4'h5, 4'h3);       // first load after reset release
        for (int n = 0; n < 200; n++)
            drive(($urandom_range(0, 15) == 0), $urandom_range(0, 1), W'($urandom), W'($urandom));
        drive(0, 0, 4'h0, 4'h0);

        for (int t = 0; t < 10 && exp_q.size() != 0; t++) @(posedge clk);
        #2;
        checks++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL drain pending=%0d want=0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule : tb_nand_gates
